// File: rtl/frame_bitmap_binarizer.sv
// frame_bitmap_binarizer
//   Converts a gapped RGB pixel stream to a 1-bit-per-pixel bitmap, stores one
//   full frame in on-chip RAM, then replays it as a contiguous 1-pixel-per-cycle
//   stream for the downstream blob counter. It holds after replay until the blob
//   counter returns its result, then rearms.
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_start               single-cycle capture+replay request (ignored while busy)
//   i_pix_valid, i_sof    input pixel strobe / start-of-frame (qualified by valid)
//   i_r, i_g, i_b         colour channels
//   i_thresh, i_invert    binarization threshold / decision inversion (latched on start)
//   i_result_valid        result pulse from the blob counter
//   o_valid, o_seq        replay stream valid / bit (1 = foreground)
//   o_busy                high from accepted start until back in idle
//   o_frame_err           sticky short-frame flag, cleared by the next start
module frame_bitmap_binarizer #(
  parameter int IMG_COL = 640,
  parameter int IMG_ROW = 480,
  parameter int PIX_W   = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_pix_valid,
  input  logic             i_sof,
  input  logic [PIX_W-1:0] i_r,
  input  logic [PIX_W-1:0] i_g,
  input  logic [PIX_W-1:0] i_b,
  input  logic [PIX_W-1:0] i_thresh,
  input  logic             i_invert,
  input  logic             i_result_valid,
  output logic             o_valid,
  output logic             o_seq,
  output logic             o_busy,
  output logic             o_frame_err
);

  localparam int N  = IMG_COL * IMG_ROW;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_CAPTURE = 3'd2,
    S_REPLAY  = 3'd3,
    S_WAIT    = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [AW-1:0]     r_cnt;
  logic [AW-1:0]     w_cnt_nxt;
  logic [PIX_W-1:0]  r_thr;
  logic [PIX_W-1:0]  w_thr_nxt;
  logic              r_inv;
  logic              w_inv_nxt;
  logic              w_err_nxt;
  logic              r_rd_done;   // all N reads issued, pipeline draining
  logic              w_rd_done_nxt;
  logic              r_rd_vld;    // a RAM read was issued on the previous edge
  logic              w_rd_vld_nxt;
  logic              r_rd_bit;
  logic              w_valid_nxt;
  logic              w_seq_nxt;
  logic              w_we;
  logic [AW-1:0]     w_waddr;
  logic [PIX_W+1:0]  w_sum;
  logic [PIX_W-1:0]  w_gray;
  logic              w_bit;

  logic              r_mem [0:N-1];

  // Gray = (R + 2G + B) >> 2 at PIX_W+2 bits so the sum cannot overflow
  assign w_sum  = {2'b00, i_r} + {1'b0, i_g, 1'b0} + {2'b00, i_b};
  assign w_gray = w_sum[PIX_W+1:2];
  assign w_bit  = (w_gray > r_thr) ^ r_inv;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = S_ARM;
        else         w_state_nxt = S_IDLE;
      end
      S_ARM: begin
        if (i_pix_valid && i_sof) w_state_nxt = S_CAPTURE;
        else                      w_state_nxt = S_ARM;
      end
      S_CAPTURE: begin
        if (i_pix_valid && !i_sof && (r_cnt == LAST)) w_state_nxt = S_REPLAY;
        else                                          w_state_nxt = S_CAPTURE;
      end
      S_REPLAY: begin
        // leave only once the last read has passed through the output register
        if (r_rd_done && !r_rd_vld) w_state_nxt = S_WAIT;
        else                        w_state_nxt = S_REPLAY;
      end
      S_WAIT: begin
        if (i_result_valid) w_state_nxt = S_IDLE;
        else                w_state_nxt = S_WAIT;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output and datapath next-value logic
  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_thr_nxt     = r_thr;
    w_inv_nxt     = r_inv;
    w_err_nxt     = o_frame_err;
    w_rd_done_nxt = r_rd_done;
    w_rd_vld_nxt  = 1'b0;
    w_we          = 1'b0;
    w_waddr       = r_cnt;
    w_valid_nxt   = r_rd_vld;
    w_seq_nxt     = r_rd_vld & r_rd_bit;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt     = '0;
        w_rd_done_nxt = 1'b0;
        if (i_start) begin
          w_thr_nxt = i_thresh;
          w_inv_nxt = i_invert;
          w_err_nxt = 1'b0;
        end else begin
          w_err_nxt = o_frame_err;
        end
      end
      S_ARM: begin
        if (i_pix_valid && i_sof) begin
          w_we      = 1'b1;
          w_waddr   = '0;
          w_cnt_nxt = AW'(1);
        end else begin
          w_cnt_nxt = '0;
        end
      end
      S_CAPTURE: begin
        if (i_pix_valid) begin
          w_we = 1'b1;
          if (i_sof) begin
            // early start-of-frame: abandon the partial frame and restart
            w_err_nxt = 1'b1;
            w_waddr   = '0;
            w_cnt_nxt = AW'(1);
          end else if (r_cnt == LAST) begin
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + AW'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      S_REPLAY: begin
        if (!r_rd_done) begin
          w_rd_vld_nxt = 1'b1;
          if (r_cnt == LAST) begin
            w_cnt_nxt     = '0;
            w_rd_done_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + AW'(1);
          end
        end else begin
          w_cnt_nxt = '0;
        end
      end
      S_WAIT: begin
        w_cnt_nxt = '0;
      end
      default: begin
        w_cnt_nxt = '0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt       <= '0;
      r_thr       <= '0;
      r_inv       <= 1'b0;
      r_rd_done   <= 1'b0;
      r_rd_vld    <= 1'b0;
      o_valid     <= 1'b0;
      o_seq       <= 1'b0;
      o_busy      <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_thr       <= w_thr_nxt;
      r_inv       <= w_inv_nxt;
      r_rd_done   <= w_rd_done_nxt;
      r_rd_vld    <= w_rd_vld_nxt;
      o_valid     <= w_valid_nxt;
      o_seq       <= w_seq_nxt;
      o_busy      <= (w_state_nxt != S_IDLE);
      o_frame_err <= w_err_nxt;
    end
  end

  // Bitmap RAM: synchronous write, 1-cycle registered read at the counter address
  always_ff @(posedge i_clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_bit;
    end
    r_rd_bit <= r_mem[r_cnt];
  end

endmodule

// File: tb/tb_frame_bitmap_binarizer.sv
module tb_frame_bitmap_binarizer;

  localparam int COLS = 8;
  localparam int ROWS = 4;
  localparam int N    = COLS * ROWS;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, pix_valid, sof, invert, result_valid;
  logic [7:0] r, g, b, thresh;
  logic       o_valid, o_seq, o_busy, o_frame_err;

  int checks = 0;
  int passes = 0;

  int pr [0:N-1];
  int pg [0:N-1];
  int pb [0:N-1];
  int thr_cur;
  bit inv_cur;
  logic [N-1:0] last_got;

  always #5 clk = ~clk;

  frame_bitmap_binarizer #(.IMG_COL(COLS), .IMG_ROW(ROWS), .PIX_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_pix_valid(pix_valid),
    .i_sof(sof), .i_r(r), .i_g(g), .i_b(b), .i_thresh(thresh), .i_invert(invert),
    .i_result_valid(result_valid), .o_valid(o_valid), .o_seq(o_seq),
    .o_busy(o_busy), .o_frame_err(o_frame_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: bitmap from the gray/threshold rule in plain integer arithmetic
  function automatic logic [N-1:0] model(input int thr, input bit inv);
    logic [N-1:0] m;
    for (int k = 0; k < N; k++) begin
      int gray;
      gray = (pr[k] + 2 * pg[k] + pb[k]) / 4;
      m[k] = (gray > thr) ^ inv;
    end
    return m;
  endfunction

  task automatic do_start(input int thr, input bit inv);
    thr_cur = thr;
    inv_cur = inv;
    start   = 1'b1;
    thresh  = thr[7:0];
    invert  = inv;
    @(negedge clk);
    start   = 1'b0;
    thresh  = 8'd0;
    invert  = 1'b0;
  endtask

  task automatic send_pixels(input int count, input int gapmax);
    for (int k = 0; k < count; k++) begin
      int gap;
      gap = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
      repeat (gap) begin
        pix_valid = 1'b0;
        sof       = $urandom_range(0, 1);  // sof without valid must be ignored
        @(negedge clk);
      end
      pix_valid = 1'b1;
      sof       = (k == 0);
      r = pr[k][7:0]; g = pg[k][7:0]; b = pb[k][7:0];
      @(negedge clk);
    end
    pix_valid = 1'b0;
    sof       = 1'b0;
  endtask

  // Called at the first falling edge after the edge that wrote the last pixel
  task automatic check_replay(input string tag, input int inj);
    logic [N-1:0] got;
    int run;
    got = '0;
    run = 0;
    chk({tag, " valid+0"}, o_valid, 1'b0);
    @(negedge clk);
    chk({tag, " valid+1"}, o_valid, 1'b0);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      if (o_valid === 1'b1) run++;
      got[k] = o_seq;
      start  = (k == inj);
      thresh = 8'd0;
      invert = 1'b1;
      @(negedge clk);
    end
    start  = 1'b0;
    invert = 1'b0;
    chk({tag, " run"}, run, N);
    chk({tag, " bits"}, got, model(thr_cur, inv_cur));
    chk({tag, " end"}, {o_valid, o_seq, o_busy}, 3'b001);
    last_got = got;
  endtask

  task automatic result_pulse(input string tag);
    result_valid = 1'b1;
    @(negedge clk);
    result_valid = 1'b0;
    chk({tag, " busy"}, o_busy, 1'b0);
  endtask

  task automatic fill_random();
    for (int k = 0; k < N; k++) begin
      pr[k] = $urandom_range(0, 255);
      pg[k] = $urandom_range(0, 255);
      pb[k] = $urandom_range(0, 255);
    end
  endtask

  initial begin
    int acc;
    rst_n = 1'b0; start = 1'b0; pix_valid = 1'b0; sof = 1'b0; invert = 1'b0;
    result_valid = 1'b0; r = 8'd0; g = 8'd0; b = 8'd0; thresh = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset outs", {o_valid, o_seq, o_busy, o_frame_err}, 4'b0000);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle outs", {o_valid, o_seq, o_busy, o_frame_err}, 4'b0000);

    // Alternating gray 10/200, contiguous
    for (int k = 0; k < N; k++) begin
      pr[k] = (k % 2 == 1) ? 200 : 10;
      pg[k] = pr[k];
      pb[k] = pr[k];
    end
    do_start(100, 1'b0);
    chk("busy after start", o_busy, 1'b1);
    send_pixels(N, 0);
    check_replay("alt", -1);
    chk("alt pattern", last_got, 32'hAAAA_AAAA);
    chk("alt err", o_frame_err, 1'b0);
    result_pulse("alt");

    // Same frame with gaps, then inverted
    do_start(100, 1'b0);
    send_pixels(N, 5);
    check_replay("gap", -1);
    chk("gap pattern", last_got, 32'hAAAA_AAAA);
    result_pulse("gap");
    do_start(100, 1'b1);
    send_pixels(N, 5);
    check_replay("inv", -1);
    chk("inv pattern", last_got, 32'h5555_5555);
    result_pulse("inv");

    // Random frames; start mid-replay and pixels during wait must be ignored
    fill_random();
    do_start($urandom_range(0, 255), 1'b0);
    send_pixels(N, 5);
    check_replay("rnd0", 5);
    send_pixels(10, 2);
    acc = 0;
    repeat (4) begin
      if (o_valid !== 1'b0) acc++;
      @(negedge clk);
    end
    chk("wait ignores pixels", {acc[7:0], o_busy}, {8'd0, 1'b1});
    result_pulse("rnd0");

    fill_random();
    do_start($urandom_range(0, 255), 1'($urandom_range(0, 1)));
    send_pixels(N, 3);
    check_replay("rnd1", -1);
    // result and start together in wait: start dropped
    result_valid = 1'b1; start = 1'b1; thresh = 8'd7;
    @(negedge clk);
    result_valid = 1'b0; start = 1'b0;
    chk("start dropped t0", o_busy, 1'b0);
    repeat (3) @(negedge clk);
    chk("start dropped t3", o_busy, 1'b0);

    // Threshold boundaries and no-overflow at full scale
    for (int k = 0; k < N; k++) begin
      pr[k] = (k % 3 == 0) ? 100 : ((k % 3 == 1) ? 101 : 255);
      pg[k] = pr[k];
      pb[k] = pr[k];
    end
    do_start(100, 1'b0);
    send_pixels(N, 1);
    check_replay("edge100", -1);
    chk("gray100 vs 100", last_got[0], 1'b0);
    chk("gray101 vs 100", last_got[1], 1'b1);
    result_pulse("edge100");
    do_start(254, 1'b0);
    send_pixels(N, 0);
    check_replay("edge254", -1);
    chk("gray255 vs 254", last_got[2:0], 3'b100);
    result_pulse("edge254");

    // Short frame: sof after 20 pixels restarts capture and flags error
    fill_random();
    do_start(128, 1'b0);
    send_pixels(20, 1);
    chk("no err yet", o_frame_err, 1'b0);
    fill_random();
    send_pixels(N, 1);
    chk("short err", o_frame_err, 1'b1);
    check_replay("short", -1);
    result_pulse("short");
    chk("err sticky", o_frame_err, 1'b1);
    do_start(128, 1'b0);
    chk("err cleared", o_frame_err, 1'b0);

    // Reset in the middle of replay
    fill_random();
    send_pixels(N, 0);
    @(negedge clk);
    @(negedge clk);
    repeat (15) @(negedge clk);
    chk("mid replay valid", o_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("async reset outs", {o_valid, o_seq, o_busy, o_frame_err}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    send_pixels(N, 0);
    acc = 0;
    repeat (40) begin
      if ((o_valid | o_busy) !== 1'b0) acc++;
      @(negedge clk);
    end
    chk("quiet after reset", acc, 0);
    fill_random();
    do_start($urandom_range(0, 255), 1'b1);
    send_pixels(N, 2);
    check_replay("post reset", -1);
    result_pulse("post reset");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
